bus_fabric_ws: RTL and testbench

//  Parametrised CPU-to-peripheral bus fabric replacing hand-written chip-select/read-mux glue in the SoC top.

---
 rtl/bus_fabric_ws.sv | 137 +++++++++++++
 tb/tb_bus_fabric_ws.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric_ws.sv
// bus_fabric_ws: CPU-to-peripheral fabric with address decode, per-slave wait-state
// insertion, registered read-return select, optional byte swap and unmapped-access capture.
module bus_fabric_ws #(
  parameter int unsigned         NSLV     = 6,
  parameter logic [NSLV*8-1:0]   SLV_BASE = 48'hF0_E0_C0_80_40_00,
  parameter logic [NSLV*8-1:0]   SLV_MASK = {NSLV{8'hFF}},
  parameter logic [NSLV*4-1:0]   SLV_WAIT = {NSLV{4'd0}},
  parameter logic [NSLV-1:0]     SLV_SWAP = {NSLV{1'b0}}
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic [3:0]           cpu_we_i,
  output logic [31:0]          cpu_data_o,
  output logic                 stall_o,
  output logic [NSLV-1:0]      slv_sel_o,
  output logic [31:0]          slv_data_o,
  output logic [3:0]           slv_we_o,
  input  logic [NSLV*32-1:0]   slv_data_i,
  output logic                 err_o,
  output logic [31:0]          err_addr_o,
  input  logic                 err_clr_i
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic              hit;
  logic [NSLV-1:0]   sel_dec;
  logic [3:0]        hit_wait;
  logic              hit_swap;
  logic              stall;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Priority decode: the first matching slave (lowest index) owns the access.
  always_comb begin
    hit      = 1'b0;
    sel_dec  = '0;
    hit_wait = 4'd0;
    hit_swap = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (!hit && ((cpu_addr_i[31:24] & SLV_MASK[8*k +: 8]) ==
                   (SLV_BASE[8*k +: 8] & SLV_MASK[8*k +: 8]))) begin
        hit        = 1'b1;
        sel_dec[k] = 1'b1;
        hit_wait   = SLV_WAIT[4*k +: 4];
        hit_swap   = SLV_SWAP[k];
      end
    end
  end

  always_comb begin
    slv_sel_o  = sel_dec;
    slv_data_o = hit_swap ? bswap32(cpu_data_i) : cpu_data_i;
    if (!hit)
      slv_we_o = 4'b0000;
    else if (hit_swap)
      slv_we_o = {cpu_we_i[0], cpu_we_i[1], cpu_we_i[2], cpu_we_i[3]};
    else
      slv_we_o = cpu_we_i;
  end

  // cnt holds the stall cycles still owed after the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit && (hit_wait != 4'd0)) begin
          stall   = 1'b1;
          cnt_d   = hit_wait - 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sel_d = stall ? sel_q : sel_dec;

    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_clr_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (!stall && !hit && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = cpu_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    cpu_data_o = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q[k])
        cpu_data_o = SLV_SWAP[k] ? bswap32(slv_data_i[32*k +: 32]) : slv_data_i[32*k +: 32];
    end
  end

  assign stall_o    = stall;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_bus_fabric_ws.sv
// Self-checking bench for bus_fabric_ws: vector table, hand-written corner
// sequences and randomized accesses checked against a transaction-level model.
module tb_bus_fabric_ws;
  localparam int NSLV = 6;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [31:0]         cpu_addr_i;
  logic [31:0]         cpu_data_i;
  logic [3:0]          cpu_we_i;
  logic [31:0]         cpu_data_o;
  logic                stall_o;
  logic [NSLV-1:0]     slv_sel_o;
  logic [31:0]         slv_data_o;
  logic [3:0]          slv_we_o;
  logic [NSLV*32-1:0]  slv_data_i;
  logic                err_o;
  logic [31:0]         err_addr_o;
  logic                err_clr_i;

  always #5 clk_i = ~clk_i;

  // slave map: 0:00 1:40 2:E1(W3) 3:80(swap) 4:C0/mask C0(W5) 5:20/mask F0(W1)
  bus_fabric_ws #(
    .NSLV     (NSLV),
    .SLV_BASE (48'h20_C0_80_E1_40_00),
    .SLV_MASK (48'hF0_C0_FF_FF_FF_FF),
    .SLV_WAIT (24'h150300),
    .SLV_SWAP (6'b001000)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_data_o (cpu_data_o),
    .stall_o    (stall_o),
    .slv_sel_o  (slv_sel_o),
    .slv_data_o (slv_data_o),
    .slv_we_o   (slv_we_o),
    .slv_data_i (slv_data_i),
    .err_o      (err_o),
    .err_addr_o (err_addr_o),
    .err_clr_i  (err_clr_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_base [NSLV] = '{8'h00, 8'h40, 8'hE1, 8'h80, 8'hC0, 8'h20};
  logic [7:0] m_mask [NSLV] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hF0};
  int         m_wait [NSLV] = '{0, 0, 3, 0, 5, 1};
  bit         m_swap [NSLV] = '{0, 0, 0, 1, 0, 0};
  logic        m_err;
  logic [31:0] m_err_addr;

  typedef struct {
    logic [31:0]     addr;
    logic [3:0]      we;
    logic [31:0]     wd;
    logic [31:0]     rd;
    logic [NSLV-1:0] e_sel;
    logic [3:0]      e_we;
    logic [31:0]     e_wd;
    int              e_st;
    logic [31:0]     e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic int m_decode(input logic [31:0] a);
    for (int k = 0; k < NSLV; k++)
      if ((a[31:24] & m_mask[k]) == (m_base[k] & m_mask[k])) return k;
    return -1;
  endfunction

  task automatic set_rdata(input logic [31:0] rd);
    for (int k = 0; k < NSLV; k++) slv_data_i[32*k +: 32] = rd + 32'(k);
  endtask

  // Entered and left at posedge+1; ends with one read of address 0 to observe read return.
  task automatic run_txn(input string nm, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d, input logic [31:0] rd,
                         input logic [NSLV-1:0] e_sel, input logic [3:0] e_we,
                         input logic [31:0] e_wd, input int e_st, input logic [31:0] e_rd);
    int st;
    st = 0;
    cpu_addr_i = a;
    cpu_we_i   = w;
    cpu_data_i = d;
    set_rdata(rd);
    @(negedge clk_i);
    chk({nm, " slv_we"}, {28'd0, slv_we_o}, {28'd0, e_we});
    chk({nm, " slv_data"}, slv_data_o, e_wd);
    for (int i = 0; i < 20; i++) begin
      chk({nm, " slv_sel"}, 32'(slv_sel_o), 32'(e_sel));
      if (!stall_o) break;
      st++;
      @(negedge clk_i);
    end
    chk({nm, " stall_cycles"}, 32'(st), 32'(e_st));
    @(posedge clk_i);
    #1;
    if (e_sel == '0 && !m_err) begin
      m_err      = 1'b1;
      m_err_addr = a;
    end
    cpu_addr_i = 32'h0;
    cpu_we_i   = 4'h0;
    @(negedge clk_i);
    chk({nm, " cpu_data"}, cpu_data_o, e_rd);
    chk({nm, " err"}, {31'd0, err_o}, {31'd0, m_err});
    chk({nm, " err_addr"}, err_addr_o, m_err_addr);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  pool [10] = '{8'h00, 8'h40, 8'hE1, 8'h80, 8'hC0, 8'h2A, 8'hFF, 8'h90, 8'h10, 8'h50};
    logic [31:0] r, a, d, rd;
    logic [3:0]  w;
    logic [7:0]  top;
    logic [NSLV-1:0] e_sel;
    int          idx;
    int          st;

    // addr, we, wdata, rdata base, exp sel, exp we, exp wdata, exp stalls, exp read data
    vecs.push_back('{32'h40000010, 4'h0, 32'h00000000, 32'hCAFEF00C, 6'b000010, 4'h0, 32'h00000000, 0, 32'hCAFEF00D});
    vecs.push_back('{32'hE1000000, 4'hF, 32'hDEADBEEF, 32'h12345670, 6'b000100, 4'hF, 32'hDEADBEEF, 3, 32'h12345672});
    vecs.push_back('{32'h80000000, 4'h3, 32'h11223344, 32'h4433220E, 6'b001000, 4'hC, 32'h44332211, 0, 32'h11223344});
    vecs.push_back('{32'h2F00ABCD, 4'h1, 32'h000000AA, 32'h00000000, 6'b100000, 4'h1, 32'h000000AA, 1, 32'h00000005});
    vecs.push_back('{32'hFF000000, 4'h0, 32'h00000000, 32'h00000100, 6'b010000, 4'h0, 32'h00000000, 5, 32'h00000104});
    vecs.push_back('{32'h00000040, 4'h8, 32'h01020304, 32'h00000020, 6'b000001, 4'h8, 32'h01020304, 0, 32'h00000020});
    vecs.push_back('{32'h80000004, 4'h8, 32'hA1B2C3D4, 32'h0A0B0C0A, 6'b001000, 4'h1, 32'hD4C3B2A1, 0, 32'h0D0C0B0A});

    rst_i = 1'b1; err_clr_i = 1'b0;
    cpu_addr_i = 32'h0; cpu_we_i = 4'h0; cpu_data_i = 32'h0;
    set_rdata(32'h5A5A0000);
    m_err = 1'b0; m_err_addr = 32'h0;

    // reset
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    chk("reset cpu_data", cpu_data_o, 32'd0);
    chk("reset err", {31'd0, err_o}, 32'd0);
    chk("reset err_addr", err_addr_o, 32'd0);
    chk("reset slv_we", {28'd0, slv_we_o}, 32'd0);
    @(posedge clk_i);
    #1;

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].rd,
              vecs[i].e_sel, vecs[i].e_we, vecs[i].e_wd, vecs[i].e_st, vecs[i].e_rd);

    // unmapped accesses: first address sticks, read data forced to zero
    run_txn("unmap1", 32'h90000004, 4'h0, 32'h0, 32'h77770000, '0, 4'h0, 32'h0, 0, 32'h0);
    run_txn("unmap2", 32'h90000008, 4'hF, 32'h12345678, 32'h77770000, '0, 4'h0, 32'h12345678, 0, 32'h0);
    chk("unmap first addr kept", err_addr_o, 32'h90000004);
    err_clr_i = 1'b1;
    @(posedge clk_i);
    #1 err_clr_i = 1'b0;
    m_err = 1'b0; m_err_addr = 32'h0;
    @(negedge clk_i);
    chk("clr err", {31'd0, err_o}, 32'd0);
    chk("clr err_addr", err_addr_o, 32'd0);
    @(posedge clk_i);
    #1;
    cpu_addr_i = 32'h90000010;
    err_clr_i  = 1'b1;
    @(posedge clk_i);
    #1 err_clr_i = 1'b0;
    cpu_addr_i = 32'h0;
    @(negedge clk_i);
    chk("clr beats new err", {31'd0, err_o}, 32'd0);
    @(posedge clk_i);
    #1;

    // reset during the second stall cycle of a W=5 access
    cpu_addr_i = 32'hC0000000;
    @(negedge clk_i);
    chk("w5 first stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    cpu_addr_i = 32'h0;
    @(negedge clk_i);
    chk("w5 second stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    m_err = 1'b0; m_err_addr = 32'h0;
    @(negedge clk_i);
    chk("post-reset stall", {31'd0, stall_o}, 32'd0);
    chk("post-reset cpu_data", cpu_data_o, 32'd0);
    @(posedge clk_i);
    #1;
    run_txn("fresh w5", 32'hC0000000, 4'h0, 32'h0, 32'h00ABCD00, 6'b010000, 4'h0, 32'h0, 5, 32'h00ABCD04);

    // randomized accesses against the transaction model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        err_clr_i  = 1'b1;
        cpu_addr_i = 32'h0;
        @(posedge clk_i);
        #1 err_clr_i = 1'b0;
        m_err = 1'b0; m_err_addr = 32'h0;
      end
      r = $urandom();
      if ($urandom_range(0, 1) == 0) top = pool[$urandom_range(0, 9)];
      else top = r[31:24];
      r  = $urandom();
      a  = {top, r[23:0]};
      d  = $urandom();
      rd = $urandom();
      r  = $urandom();
      w  = r[3:0];
      idx = m_decode(a);
      if (idx < 0) begin
        run_txn($sformatf("rnd%0d", n), a, w, d, rd, '0, 4'h0, d, 0, 32'h0);
      end else begin
        e_sel = '0;
        e_sel[idx] = 1'b1;
        st = m_wait[idx];
        run_txn($sformatf("rnd%0d", n), a, w, d, rd, e_sel,
                m_swap[idx] ? {w[0], w[1], w[2], w[3]} : w,
                m_swap[idx] ? bswap(d) : d, st,
                m_swap[idx] ? bswap(rd + 32'(idx)) : rd + 32'(idx));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
